payment_collector: RTL

// - Consumer side of the dispenser's pricing path: takes a priced order (final_price, volume_l), collects coins, opens the valve, counts flow-meter litres, then settles change.
// - Sits after fluid_dispenser; one order in flight at a time.

---
 rtl/fluid_pkg.sv | 23 ++
 rtl/payment_collector_if.sv | 40 ++++
 rtl/flow_meter_counter.sv | 41 ++++
 rtl/payment_collector.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/fluid_pkg.sv
// Shared types and default widths for the fluid dispenser pricing/payment path.
// The payment_collector timeout feature is enabled by defining PAYMENT_TIMEOUT_EN.
package fluid_pkg;

    localparam int DEF_PRICE_W = 16;
    localparam int DEF_COIN_W  = 8;
    localparam int DEF_VOL_W   = 8;

    typedef enum logic [1:0] {
        FLUID_WATER = 2'd0,
        FLUID_JUICE = 2'd1,
        FLUID_CHEM  = 2'd2
    } fluid_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PAY      = 3'd1,
        DISPENSE = 3'd2,
        SETTLE   = 3'd3,
        REFUND   = 3'd4
    } pc_state_t;

endpackage

// File: rtl/payment_collector_if.sv
// Order, coin, flow-meter and settlement signals between the customer side and payment_collector.
interface payment_collector_if
    import fluid_pkg::*;
#(
    parameter int PRICE_W = DEF_PRICE_W,
    parameter int COIN_W  = DEF_COIN_W,
    parameter int VOL_W   = DEF_VOL_W
);

    logic               order_valid;
    logic               order_ready;
    logic [PRICE_W-1:0] order_price;
    logic [VOL_W-1:0]   order_volume;
    logic               coin_valid;
    logic [COIN_W-1:0]  coin_value;
    logic               coin_accept;
    logic               cancel;
    logic               flow_pulse;
    logic               valve_open;
    logic [PRICE_W-1:0] paid_total;
    logic               change_valid;
    logic [PRICE_W-1:0] change_amount;
    logic               done;
    logic               aborted;

    modport master (
        output order_valid, order_price, order_volume,
        output coin_valid, coin_value, cancel, flow_pulse,
        input  order_ready, coin_accept, valve_open, paid_total,
        input  change_valid, change_amount, done, aborted
    );

    modport slave (
        input  order_valid, order_price, order_volume,
        input  coin_valid, coin_value, cancel, flow_pulse,
        output order_ready, coin_accept, valve_open, paid_total,
        output change_valid, change_amount, done, aborted
    );

endinterface

// File: rtl/flow_meter_counter.sv
// Litre counter for the dispense phase: clear, count enable and a terminal flag that
// fires in the cycle whose pulse brings the count up to the target.
module flow_meter_counter #(
    parameter int VOL_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [VOL_W-1:0] target_i,
    output logic             tc_o
);

    logic [VOL_W-1:0] count_q;
    logic [VOL_W-1:0] count_d;
    logic [VOL_W-1:0] count_inc;

    assign count_inc = count_q + VOL_W'(1);

    // NOTE: every signal assigned in a combinational block gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_inc;
        end
    end

    assign tc_o = en_i && !clear_i && (count_inc == target_i);

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/payment_collector.sv
// Collects coins for one priced order, opens the valve for the ordered litres, then settles change.
// Define PAYMENT_TIMEOUT_EN to auto-refund after TIMEOUT_CYC coinless cycles in PAY.
module payment_collector
    import fluid_pkg::*;
#(
    parameter int PRICE_W     = DEF_PRICE_W,
    parameter int COIN_W      = DEF_COIN_W,
    parameter int VOL_W       = DEF_VOL_W,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                clk,
    input  logic                reset,
    payment_collector_if.slave  bus
);

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    pc_state_t          state_q, state_d;
    logic [PRICE_W-1:0] price_q, price_d;
    logic [VOL_W-1:0]   vol_q, vol_d;
    logic [PRICE_W-1:0] paid_q, paid_d;

    logic [PRICE_W:0]   paid_sum;
    logic [PRICE_W-1:0] paid_next;
    logic               cnt_clear;
    logic               cnt_en;
    logic               cnt_tc;

    // One extra carry bit detects overflow so the running total saturates instead of wrapping.
    assign paid_sum  = {1'b0, paid_q} + (PRICE_W + 1)'(bus.coin_value);
    assign paid_next = !bus.coin_valid ? paid_q :
                       paid_sum[PRICE_W] ? {PRICE_W{1'b1}} : paid_sum[PRICE_W-1:0];

`ifdef PAYMENT_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              timeout;

    assign timeout = (state_q == PAY) && !bus.coin_valid &&
                     ((idle_q + IDLE_W'(1)) == IDLE_W'(TIMEOUT_CYC));

    always_comb begin
        idle_d = '0;
        if ((state_q == PAY) && !bus.coin_valid) begin
            idle_d = idle_q + IDLE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        price_d   = price_q;
        vol_d     = vol_q;
        paid_d    = paid_q;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.order_valid) begin
                    price_d   = bus.order_price;
                    vol_d     = bus.order_volume;
                    paid_d    = '0;
                    cnt_clear = 1'b1;
                    if (bus.order_price != '0) begin
                        state_d = PAY;
                    end else if (bus.order_volume != '0) begin
                        state_d = DISPENSE;
                    end else begin
                        state_d = SETTLE;
                    end
                end
            end

            PAY: begin
                paid_d = paid_next;
                if (bus.cancel) begin
                    state_d = REFUND;
                end else if (paid_next >= price_q) begin
                    state_d = (vol_q != '0) ? DISPENSE : SETTLE;
                end
`ifdef PAYMENT_TIMEOUT_EN
                else if (timeout) begin
                    state_d = REFUND;
                end
`endif
            end

            DISPENSE: begin
                cnt_en = bus.flow_pulse;
                if (cnt_tc) begin
                    state_d = SETTLE;
                end
            end

            SETTLE:  state_d = IDLE;
            REFUND:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            price_q <= '0;
            vol_q   <= '0;
            paid_q  <= '0;
        end else begin
            state_q <= state_d;
            price_q <= price_d;
            vol_q   <= vol_d;
            paid_q  <= paid_d;
        end
    end

    flow_meter_counter #(
        .VOL_W (VOL_W)
    ) u_flow_meter (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (cnt_clear),
        .en_i     (cnt_en),
        .target_i (vol_q),
        .tc_o     (cnt_tc)
    );

    // Moore outputs: decoded only from the registered state and datapath registers.
    always_comb begin
        bus.order_ready   = (state_q == IDLE);
        bus.coin_accept   = (state_q == PAY);
        bus.valve_open    = (state_q == DISPENSE);
        bus.paid_total    = paid_q;
        bus.done          = (state_q == SETTLE);
        bus.aborted       = (state_q == REFUND);
        bus.change_valid  = 1'b0;
        bus.change_amount = '0;

        if (state_q == SETTLE) begin
            bus.change_valid = (paid_q > price_q);
            if (paid_q > price_q) begin
                bus.change_amount = paid_q - price_q;
            end
        end else if (state_q == REFUND) begin
            bus.change_valid  = (paid_q != '0);
            bus.change_amount = paid_q;
        end
    end

endmodule
